// File: rtl/incr_arbiter_2.sv
// Two-requester round-robin arbiter in front of one shared ripple incrementor.
// The winning operand is latched, incremented with carry-in 1 through a chain of
// NAND-built half adders, and the result is offered on a valid/ready port tagged
// with the requester ID. The ripple result is registered once inside CALC before
// it is presented, so a transaction accepted at edge N shows out_valid from N+2.
module incr_arbiter_2 #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req0_i,
    input  logic [Width-1:0] din0_i,
    output logic             gnt0_o,
    input  logic             req1_i,
    input  logic [Width-1:0] din1_i,
    output logic             gnt1_o,
    output logic             busy_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_id_o,
    output logic [Width-1:0] out_sum_o,
    output logic             out_carry_o
);

    typedef enum logic [1:0] {StIdle, StCalc, StHold} state_e;

    state_e           state_q, state_d;
    logic             calc_ph_q, calc_ph_d;   // 0: ripple settling, 1: present result
    logic             prio_q, prio_d;
    logic [Width-1:0] op_q, op_d;
    logic             id_q, id_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic [Width-1:0] res_sum_q, res_sum_d;
    logic             res_carry_q, res_carry_d;
    logic             out_id_q, out_id_d;
    logic [Width-1:0] out_sum_q, out_sum_d;
    logic             out_carry_q, out_carry_d;

    logic [Width-1:0] inc_s;
    logic             inc_co;
    logic             inc_c;
    logic             inc_n;
    logic             pick;

    // Shared incrementor: ripple of NAND-only half adders, carry-in fixed at 1.
    always_comb begin
        inc_s  = '0;
        inc_c  = 1'b1;
        inc_n  = 1'b1;
        for (int i = 0; i < Width; i++) begin
            inc_n    = ~(op_q[i] & inc_c);
            inc_s[i] = ~(~(op_q[i] & inc_n) & ~(inc_c & inc_n));
            inc_c    = ~inc_n;
        end
        inc_co = inc_c;
    end

    // Next-state and arbitration decisions.
    always_comb begin
        state_d     = state_q;
        calc_ph_d   = calc_ph_q;
        prio_d      = prio_q;
        op_d        = op_q;
        id_d        = id_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        res_sum_d   = res_sum_q;
        res_carry_d = res_carry_q;
        out_id_d    = out_id_q;
        out_sum_d   = out_sum_q;
        out_carry_d = out_carry_q;
        pick        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0_i || req1_i) begin
                    // Tie goes to prio; otherwise the lone requester wins.
                    pick      = (req0_i && req1_i) ? prio_q : req1_i;
                    op_d      = pick ? din1_i : din0_i;
                    id_d      = pick;
                    gnt0_d    = ~pick;
                    gnt1_d    = pick;
                    calc_ph_d = 1'b0;
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                if (!calc_ph_q) begin
                    res_sum_d   = inc_s;
                    res_carry_d = inc_co;
                    calc_ph_d   = 1'b1;
                end else begin
                    out_sum_d   = res_sum_q;
                    out_carry_d = res_carry_q;
                    out_id_d    = id_q;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (out_ready_i) begin
                    prio_d  = ~out_id_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            calc_ph_q   <= 1'b0;
            prio_q      <= 1'b0;
            op_q        <= '0;
            id_q        <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            res_sum_q   <= '0;
            res_carry_q <= 1'b0;
            out_id_q    <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            calc_ph_q   <= calc_ph_d;
            prio_q      <= prio_d;
            op_q        <= op_d;
            id_q        <= id_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            res_sum_q   <= res_sum_d;
            res_carry_q <= res_carry_d;
            out_id_q    <= out_id_d;
            out_sum_q   <= out_sum_d;
            out_carry_q <= out_carry_d;
        end
    end

    assign gnt0_o      = gnt0_q;
    assign gnt1_o      = gnt1_q;
    assign busy_o      = (state_q != StIdle);
    assign out_valid_o = (state_q == StHold);
    assign out_id_o    = out_id_q;
    assign out_sum_o   = out_sum_q;
    assign out_carry_o = out_carry_q;

endmodule

// File: tb/tb_incr_arbiter_2.sv
// Bench for incr_arbiter_2: directed steps followed by random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_incr_arbiter_2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] din0 = '0, din1 = '0;
    logic       ready = 1'b0;
    logic       gnt0, gnt1, busy, out_valid, out_id, out_carry;
    logic [3:0] out_sum;

    int nchecks = 0;
    int nerrors = 0;

    // Reference model: a transaction is accepted, its result appears two edges
    // later, and it retires on the first edge that sees ready.
    bit         m_busy, m_prio, m_owner;
    int         m_age;
    logic [3:0] m_op;
    logic       e_gnt0, e_gnt1, e_valid, e_id, e_carry;
    logic [3:0] e_sum;

    incr_arbiter_2 #(.Width(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req0_i      (req0),
        .din0_i      (din0),
        .gnt0_o      (gnt0),
        .req1_i      (req1),
        .din1_i      (din1),
        .gnt1_o      (gnt1),
        .busy_o      (busy),
        .out_valid_o (out_valid),
        .out_ready_i (ready),
        .out_id_o    (out_id),
        .out_sum_o   (out_sum),
        .out_carry_o (out_carry)
    );

    always #5 clk = ~clk;

    task model_edge();
        if (!rst_n) begin
            m_busy = 0; m_prio = 0; m_owner = 0; m_age = 0; m_op = '0;
            e_gnt0 = 0; e_gnt1 = 0; e_valid = 0; e_id = 0; e_carry = 0; e_sum = '0;
        end else begin
            e_gnt0 = 0;
            e_gnt1 = 0;
            if (!m_busy) begin
                if (req0 || req1) begin
                    m_owner = (req0 && req1) ? m_prio : req1;
                    m_op    = m_owner ? din1 : din0;
                    e_gnt0  = !m_owner;
                    e_gnt1  = m_owner;
                    m_busy  = 1;
                    m_age   = 0;
                end
            end else if (!e_valid) begin
                m_age++;
                if (m_age == 2) begin
                    e_valid = 1;
                    e_sum   = 4'((int'(m_op) + 1) % 16);
                    e_carry = (m_op == 4'd15);
                    e_id    = m_owner;
                end
            end else if (ready) begin
                e_valid = 0;
                m_prio  = !m_owner;
                m_busy  = 0;
            end
        end
    endtask

    task chk(input string tag, input int obs, input int exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task check_all();
        chk("gnt0", int'(gnt0), int'(e_gnt0));
        chk("gnt1", int'(gnt1), int'(e_gnt1));
        chk("busy", int'(busy), int'(m_busy));
        chk("out_valid", int'(out_valid), int'(e_valid));
        chk("out_id", int'(out_id), int'(e_id));
        chk("out_sum", int'(out_sum), int'(e_sum));
        chk("out_carry", int'(out_carry), int'(e_carry));
    endtask

    // Inputs change at the negedge; the model and DUT both see them at the posedge.
    task tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int g;

        // Reset
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Single request, held result then handshake
        req0 = 1; din0 = 4'h7; tick();
        req0 = 0; tick(); tick();
        chk("single_sum", int'(out_sum), 8);
        chk("single_carry", int'(out_carry), 0);
        chk("single_valid", int'(out_valid), 1);
        ready = 1; tick();
        chk("single_drop", int'(out_valid), 0);

        // Wrap-around and near-wrap
        ready = 0; req1 = 1; din1 = 4'hF; tick();
        req1 = 0; tick(); tick();
        chk("wrap_sum", int'(out_sum), 0);
        chk("wrap_carry", int'(out_carry), 1);
        chk("wrap_id", int'(out_id), 1);
        ready = 1; tick();
        req1 = 1; din1 = 4'hE; tick();
        req1 = 0; tick(); tick();
        chk("near_sum", int'(out_sum), 15);
        chk("near_carry", int'(out_carry), 0);
        tick();

        // Contention after reset: strict alternation, one grant per 4 cycles
        rst_n = 0; tick(); rst_n = 1;
        req0 = 1; req1 = 1; din0 = 4'h2; din1 = 4'hA; ready = 1;
        g = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (gnt0 || gnt1) begin
                chk("alternate", int'(gnt1), g % 2);
                chk("alt_id_next", int'(gnt1), int'(m_owner));
                g++;
            end
        end
        chk("grant_count", g, 4);
        req0 = 0; req1 = 0;
        repeat (4) tick();

        // Backpressure in HOLD with req1 pulsing
        ready = 0; req0 = 1; din0 = 4'h3; tick();
        req0 = 0; tick(); tick();
        for (int i = 0; i < 5; i++) begin
            req1 = (i % 2 == 0); din1 = 4'h9;
            tick();
            chk("bp_sum", int'(out_sum), 4);
        end
        req1 = 1; ready = 1; tick();
        chk("bp_no_gnt_at_handshake", int'(gnt1), 0);
        tick();
        chk("bp_served_after", int'(gnt1), 1);
        req1 = 0;
        repeat (3) tick();

        // Reset in CALC
        req0 = 1; din0 = 4'h5; tick();
        req0 = 0; rst_n = 0; tick();
        rst_n = 1;
        repeat (3) tick();
        // Reset in HOLD
        ready = 0; req0 = 1; din0 = 4'h6; tick();
        req0 = 0; tick(); tick();
        rst_n = 0; tick();
        rst_n = 1; ready = 1;
        chk("rst_hold_valid", int'(out_valid), 0);
        req0 = 1; req1 = 1; din0 = 4'h1; din1 = 4'h4; tick();
        chk("rst_tie_gnt0", int'(gnt0), 1);
        req0 = 0;
        repeat (4) tick();
        req1 = 0;
        repeat (4) tick();

        // Sweep requester 0 over all operands
        for (int i = 0; i < 16; i++) begin
            req0 = 1; din0 = 4'(i); tick();
            req0 = 0; tick(); tick();
            chk("sweep_sum", int'(out_sum), (i + 1) % 16);
            chk("sweep_carry", int'(out_carry), (i == 15) ? 1 : 0);
            tick();
        end

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(99, 0) != 0);
            ready = ($urandom_range(9, 0) < 7);
            if (e_gnt0) begin
                if ($urandom_range(1, 0) == 1) req0 = 0;
                else din0 = 4'($urandom_range(15, 0));
            end else if (!req0 && $urandom_range(2, 0) == 0) begin
                req0 = 1; din0 = 4'($urandom_range(15, 0));
            end
            if (e_gnt1) begin
                if ($urandom_range(1, 0) == 1) req1 = 0;
                else din1 = 4'($urandom_range(15, 0));
            end else if (!req1 && $urandom_range(2, 0) == 0) begin
                req1 = 1; din1 = 4'($urandom_range(15, 0));
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
